rv_test_host: RTL and testbench

- Memory-mapped test-host peripheral on the core's data bus. The core writes the RVTEST pass/fail word to it, and it raises done/pass/fail_code to the simulation harness.
- It also carries a byte console: core writes are buffered in a FIFO and drained over a valid/ready stream.
- A cycle watchdog forces a failing halt when the program never reports.
- It is the core-facing end of the halt/pass-fail protocol. It replaces ecall snooping plus the gp==1 check with an explicit device.

---
 rtl/rv_test_host_if.sv | 23 ++
 rtl/rv_test_host.sv | 132 +++++++++++++
 tb/tb_rv_test_host.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_test_host_if.sv
// rtl/rv_test_host_if.sv - core data-bus access and console byte stream bundle
interface rv_test_host_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output req, we, addr, wdata, tx_ready,
    input  ready, rdata, rvalid, tx_data, tx_valid
  );

  modport slave (
    input  req, we, addr, wdata, tx_ready,
    output ready, rdata, rvalid, tx_data, tx_valid
  );
endinterface

// File: rtl/rv_test_host.sv
// rtl/rv_test_host.sv - test-host peripheral: tohost halt word, console FIFO, cycle watchdog
module rv_test_host #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 5000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  rv_test_host_if.slave bus,
  output logic          done_o,
  output logic          pass_o,
  output logic [30:0]   fail_code_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d, pass_q, pass_d;
  logic [30:0]   fail_q, fail_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic          hit, empty, full, pop, push, con_wr, tohost_halt, wd_fire;
  logic [1:0]    off;
  logic [4:0]    cnt_field;
  logic [31:0]   rd_mux;

  // Window decode, FIFO flags and the console back-pressure that gates ready
  always_comb begin
    hit         = bus.req && (bus.addr[31:4] == BASE_ADDR[31:4]);
    off         = bus.addr[3:2];
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    pop         = !empty && bus.tx_ready;
    con_wr      = hit && bus.we && (off == 2'd1);
    bus.ready   = bus.req && !(con_wr && full && !pop);
    push        = con_wr && bus.ready;
    tohost_halt = hit && bus.we && (off == 2'd0) && !done_q && bus.wdata[0];
    wd_fire     = (TIMEOUT != 0) && !done_q && (cyc_q == TIMEOUT_LAST);
  end

  // Read mux; rdata holds its last value between reads, rvalid pulses once per read
  always_comb begin
    cnt_field = 5'(count_q);
    rd_mux    = '0;
    if (hit) begin
      case (off)
        2'd0:    rd_mux = {fail_q, done_q};
        2'd2:    rd_mux = {19'd0, cnt_field, 5'd0, full, pass_q, done_q};
        2'd3:    rd_mux = cyc_q;
        default: rd_mux = '0;
      endcase
    end
    rvalid_d = bus.req && !bus.we;
    rdata_d  = rvalid_d ? rd_mux : rdata_q;
  end

  // Halt status and cycle counter; a core halt outranks a simultaneous watchdog expiry
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    fail_d = fail_q;
    cyc_d  = cyc_q;
    if (!done_q && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
    if (tohost_halt) begin
      done_d = 1'b1;
      if (bus.wdata == 32'd1) begin
        pass_d = 1'b1;
        fail_d = '0;
      end else begin
        pass_d = 1'b0;
        fail_d = bus.wdata[31:1];
      end
    end else if (wd_fire) begin
      done_d = 1'b1;
      pass_d = 1'b0;
      fail_d = '1;
    end
  end

  // FIFO pointers wrap naturally because the depth is a power of two
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Console storage needs no reset: count_q alone says which entries are live
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.wdata[7:0];
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
      cyc_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      cyc_q    <= cyc_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.tx_data  = mem_q[rd_ptr_q];
  assign bus.tx_valid = !empty;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_code_o  = fail_q;

endmodule

// File: tb/tb_rv_test_host.sv
// tb/tb_rv_test_host.sv - self-checking bench for rv_test_host
module tb_rv_test_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_nb;
  logic        done_a, pass_a, done_b, pass_b;
  logic [30:0] fail_a, fail_b;

  rv_test_host_if a_if ();
  rv_test_host_if b_if ();

  rv_test_host #(.BASE_ADDR(32'h0000_1000), .FIFO_DEPTH(8), .TIMEOUT(5000)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(a_if),
    .done_o(done_a), .pass_o(pass_a), .fail_code_o(fail_a)
  );

  rv_test_host #(.BASE_ADDR(32'h0000_1000), .FIFO_DEPTH(8), .TIMEOUT(20)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .bus(b_if),
    .done_o(done_b), .pass_o(pass_b), .fail_code_o(fail_b)
  );

  int checks   = 0;
  int failures = 0;
  int tb_cyc   = 0;
  int rel_cyc  = 0;
  int done_cyc = -1;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t    rdq[$];
  logic [7:0] txq[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [31:0] exp_rdata;
    logic        exp_done;
    logic        exp_pass;
    logic [30:0] exp_fail;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // read-data scoreboard: each accepted read is due exactly one edge later
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdq.size() > 0 && rdq[0].due == tb_cyc) begin
        chk("rvalid", 32'(a_if.rvalid), 32'd1);
        chk("rdata", a_if.rdata, rdq[0].data);
        void'(rdq.pop_front());
      end else if (a_if.rvalid) begin
        chk("rvalid_spurious", 32'(a_if.rvalid), 32'd0);
      end
    end
  end

  // console scoreboard: compare each byte that will pop at the coming edge
  always @(negedge clk) begin
    #2;
    if (rst_n && a_if.tx_valid && a_if.tx_ready) begin
      if (txq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra actual=%h required=none", a_if.tx_data);
      end else begin
        chk("tx_data", 32'(a_if.tx_data), 32'(txq.pop_front()));
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic txr, input logic exp_ready, input logic [31:0] exp_rdata,
                        input string name);
    @(negedge clk);
    a_if.req      = 1'b1;
    a_if.we       = we;
    a_if.addr     = addr;
    a_if.wdata    = wdata;
    a_if.tx_ready = txr;
    #1;
    chk({name, "_ready"}, 32'(a_if.ready), 32'(exp_ready));
    if (exp_ready && !we) rdq.push_back('{data: exp_rdata, due: tb_cyc + 1});
    if (exp_ready && we && addr[31:4] == 28'h000_0100 && addr[3:2] == 2'd1)
      txq.push_back(wdata[7:0]);
    @(posedge clk);
    #1;
    a_if.req      = 1'b0;
    a_if.tx_ready = 1'b0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_n         = 1'b0;
    a_if.req      = 1'b0;
    a_if.tx_ready = 1'b0;
    rdq.delete();
    txq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = tb_cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; rst_nb = 1'b0;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0; a_if.tx_ready = 1'b0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0; b_if.tx_ready = 1'b0;

    //                we    addr          wdata         rdy   rdata         done  pass  fail
    vt[0]  = '{1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 31'd0};
    vt[1]  = '{1'b1, 32'h0000_1000, 32'h6,        1'b1, 32'h0,        1'b0, 1'b0, 31'd0};
    vt[2]  = '{1'b0, 32'h0000_1008, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 31'd0};
    vt[3]  = '{1'b1, 32'h0000_1004, 32'h41,       1'b1, 32'h0,        1'b0, 1'b0, 31'd0};
    vt[4]  = '{1'b0, 32'h0000_1008, 32'h0,        1'b1, 32'h100,      1'b0, 1'b0, 31'd0};
    vt[5]  = '{1'b1, 32'h0000_2000, 32'h1,        1'b1, 32'h0,        1'b0, 1'b0, 31'd0};
    vt[6]  = '{1'b0, 32'h0000_2000, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 31'd0};
    vt[7]  = '{1'b1, 32'h0000_1000, 32'h7,        1'b1, 32'h0,        1'b1, 1'b0, 31'd3};
    vt[8]  = '{1'b1, 32'h0000_1000, 32'h1,        1'b1, 32'h0,        1'b1, 1'b0, 31'd3};
    vt[9]  = '{1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'h7,        1'b1, 1'b0, 31'd3};
    vt[10] = '{1'b0, 32'h0000_1008, 32'h0,        1'b1, 32'h101,      1'b1, 1'b0, 31'd3};
    vt[11] = '{1'b0, 32'h0000_1003, 32'h0,        1'b1, 32'h7,        1'b1, 1'b0, 31'd3};
    vt[12] = '{1'b0, 32'h0000_1004, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 31'd3};
    vt[13] = '{1'b1, 32'h0000_2004, 32'h55,       1'b1, 32'h0,        1'b1, 1'b0, 31'd3};
    vt[14] = '{1'b0, 32'h0000_1008, 32'h0,        1'b1, 32'h101,      1'b1, 1'b0, 31'd3};

    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_fail", 32'(fail_a), 32'd0);
    chk("rst_rvalid", 32'(a_if.rvalid), 32'd0);
    chk("rst_rdata", a_if.rdata, 32'd0);
    chk("rst_tx_valid", 32'(a_if.tx_valid), 32'd0);

    // watchdog: done rises on exactly the 20th edge after release
    rst_nb  = 1'b1;
    rel_cyc = tb_cyc;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("wd_done_%0d", k), 32'(done_b), 32'(k == 20));
    end
    chk("wd_pass", 32'(pass_b), 32'd0);
    chk("wd_fail", 32'(fail_b), 32'h7FFF_FFFF);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 32'h0000_100C;
      #1;
      chk("wd_cyc_ready", 32'(b_if.ready), 32'd1);
      @(negedge clk);
      b_if.req = 1'b0;
      chk("wd_cyc_rvalid", 32'(b_if.rvalid), 32'd1);
      chk("wd_cyc_rdata", b_if.rdata, 32'd20);
      repeat (3) @(negedge clk);
    end

    // core halt in the same cycle as the timeout wins
    @(negedge clk);
    rst_nb = 1'b0;
    @(negedge clk);
    rst_nb  = 1'b1;
    rel_cyc = tb_cyc;
    while (tb_cyc - rel_cyc != 19) @(negedge clk);
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 32'h0000_1000; b_if.wdata = 32'h5;
    @(posedge clk);
    #1;
    b_if.req = 1'b0;
    chk("prio_done", 32'(done_b), 32'd1);
    chk("prio_pass", 32'(pass_b), 32'd0);
    chk("prio_fail", 32'(fail_b), 32'd2);

    // table vectors on the main instance
    reset_a();
    for (int i = 0; i < 15; i++) begin
      access(vt[i].we, vt[i].addr, vt[i].wdata, 1'b0, vt[i].exp_ready, vt[i].exp_rdata,
             $sformatf("vec%0d", i));
      if (done_a && done_cyc < 0) done_cyc = tb_cyc;
      chk($sformatf("vec%0d_done", i), 32'(done_a), 32'(vt[i].exp_done));
      chk($sformatf("vec%0d_pass", i), 32'(pass_a), 32'(vt[i].exp_pass));
      chk($sformatf("vec%0d_fail", i), 32'(fail_a), 32'(vt[i].exp_fail));
    end
    access(1'b0, 32'h0000_100C, 32'h0, 1'b0, 1'b1, 32'(done_cyc - rel_cyc), "cyc_frozen0");
    repeat (4) @(negedge clk);
    access(1'b0, 32'h0000_100C, 32'h0, 1'b0, 1'b1, 32'(done_cyc - rel_cyc), "cyc_frozen1");

    // passing halt
    reset_a();
    access(1'b1, 32'h0000_1000, 32'h1, 1'b0, 1'b1, 32'h0, "pass_wr");
    chk("pass_done", 32'(done_a), 32'd1);
    chk("pass_pass", 32'(pass_a), 32'd1);
    chk("pass_fail", 32'(fail_a), 32'd0);
    access(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 32'h3, "pass_status");

    // console fill, stall, simultaneous push/pop at full, then drain
    reset_a();
    for (int i = 0; i < 8; i++)
      access(1'b1, 32'h0000_1004, 32'(8'h41 + i), 1'b0, 1'b1, 32'h0, $sformatf("fill%0d", i));
    access(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 32'h804, "full_status");
    access(1'b1, 32'h0000_1004, 32'h49, 1'b0, 1'b0, 32'h0, "stall");
    access(1'b1, 32'h0000_1004, 32'h49, 1'b1, 1'b1, 32'h0, "push_pop_full");
    access(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 32'h804, "still_full");
    @(negedge clk);
    a_if.tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    a_if.tx_ready = 1'b0;
    #1;
    chk("drain_left", 32'(txq.size()), 32'd0);
    chk("drain_tx_valid", 32'(a_if.tx_valid), 32'd0);
    access(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 32'h0, "empty_status");

    // asynchronous reset with bytes queued and a sticky halt
    for (int i = 0; i < 3; i++)
      access(1'b1, 32'h0000_1004, 32'(8'h61 + i), 1'b0, 1'b1, 32'h0, $sformatf("q%0d", i));
    access(1'b1, 32'h0000_1000, 32'h1, 1'b0, 1'b1, 32'h0, "halt_before_rst");
    access(1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 32'h1, "rd_before_rst");
    @(negedge clk);
    #3;
    chk("pre_rst_done", 32'(done_a), 32'd1);
    chk("pre_rst_tx_valid", 32'(a_if.tx_valid), 32'd1);
    chk("pre_rst_rdata", a_if.rdata, 32'h1);
    rst_n = 1'b0;
    rdq.delete();
    txq.delete();
    #1;
    chk("async_done", 32'(done_a), 32'd0);
    chk("async_pass", 32'(pass_a), 32'd0);
    chk("async_tx_valid", 32'(a_if.tx_valid), 32'd0);
    chk("async_rdata", a_if.rdata, 32'd0);
    chk("async_rvalid", 32'(a_if.rvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = tb_cyc;
    access(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 32'h0, "post_rst_status");

    repeat (3) @(negedge clk);
    chk("reads_pending", 32'(rdq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
